// File: rtl/merge_unit.sv
// Merges two ascending runs of RUN_LEN unsigned words into one ascending run of 2*RUN_LEN words.
// Ties take the left word first, and dup flags runs that saw equal heads.

module merge_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_lt,
  output logic         a_eq
);
  // Each half is compared on its own, then the results are combined, which keeps the carry chains short.
  if (W < 2) begin : g_narrow
    assign a_lt = (a < b);
    assign a_eq = (a == b);
  end else begin : g_split
    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [HI-1:0] a_hi, b_hi;
    logic [LO-1:0] a_lo, b_lo;
    logic          hi_lt, hi_eq, lo_lt, lo_eq;

    assign a_hi  = a[W-1:LO];
    assign b_hi  = b[W-1:LO];
    assign a_lo  = a[LO-1:0];
    assign b_lo  = b[LO-1:0];
    assign hi_lt = (a_hi < b_hi);
    assign hi_eq = (a_hi == b_hi);
    assign lo_lt = (a_lo < b_lo);
    assign lo_eq = (a_lo == b_lo);
    assign a_lt  = hi_lt | (hi_eq & lo_lt);
    assign a_eq  = hi_eq & lo_eq;
  end
endmodule

// state   | meaning
// IDLE    | after reset only; moves to MERGE on the next cycle
// MERGE   | both runs still have words; take the smaller head (L on ties)
// DRAIN_L | right run is exhausted; pass the rest of the left run
// DRAIN_R | left run is exhausted; pass the rest of the right run
module merge_unit #(
  parameter int WIDTH   = 32,
  parameter int RUN_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dinL,
  input  logic             dinL_valid,
  output logic             dinL_ready,
  input  logic [WIDTH-1:0] dinR,
  input  logic             dinR_valid,
  output logic             dinR_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             dup
);
  localparam int CW = $clog2(RUN_LEN) + 1;
  localparam logic [CW-1:0] RUN_END = CW'(RUN_LEN);
  localparam logic [CW:0]   TOT_END = (CW + 1)'(2 * RUN_LEN);

  typedef enum logic [1:0] {IDLE, MERGE, DRAIN_L, DRAIN_R} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt_l, cnt_r, cnt_l_nxt, cnt_r_nxt;
  logic          dup_flag;
  logic          l_smaller, eq;
  logic          load_ok, take_l, take_r, run_done, dup_hit;

  merge_cmp #(.W(WIDTH)) u_cmp (
    .a    (dinL),
    .b    (dinR),
    .a_lt (l_smaller),
    .a_eq (eq)
  );

  always_comb begin
    load_ok   = !dout_valid || dout_ready;
    take_l    = 1'b0;
    take_r    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = MERGE;
      MERGE: begin
        if (load_ok && dinL_valid && dinR_valid) begin
          if (l_smaller || eq) take_l = 1'b1;
          else                 take_r = 1'b1;
        end
      end
      DRAIN_L: take_l = load_ok && dinL_valid;
      DRAIN_R: take_r = load_ok && dinR_valid;
      default: state_nxt = IDLE;
    endcase

    cnt_l_nxt = cnt_l + CW'(take_l);
    cnt_r_nxt = cnt_r + CW'(take_r);
    run_done  = (({1'b0, cnt_l_nxt} + {1'b0, cnt_r_nxt}) == TOT_END);
    dup_hit   = (state == MERGE) && (take_l || take_r) && eq;

    // Both counters cannot reach RUN_LEN in MERGE on the same edge, so the order here is irrelevant.
    if (run_done) begin
      state_nxt = MERGE;
    end else if (state == MERGE) begin
      if (cnt_l_nxt == RUN_END)      state_nxt = DRAIN_R;
      else if (cnt_r_nxt == RUN_END) state_nxt = DRAIN_L;
    end
  end

  assign dinL_ready = take_l;
  assign dinR_ready = take_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt_l      <= '0;
      cnt_r      <= '0;
      dup_flag   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      dup        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_l || take_r) begin
        cnt_l      <= run_done ? '0 : cnt_l_nxt;
        cnt_r      <= run_done ? '0 : cnt_r_nxt;
        dout       <= take_l ? dinL : dinR;
        dout_valid <= 1'b1;
        dout_last  <= run_done;
        dup        <= run_done && (dup_flag || dup_hit);
        dup_flag   <= run_done ? 1'b0 : (dup_flag || dup_hit);
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
        dup        <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_merge_unit.sv
// Directed bench for merge_unit at RUN_LEN=4: a bench-side stable merge fills a scoreboard
// that is compared against every output word.

module tb_merge_unit;
  localparam int W = 32;
  localparam int RL = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] dinL = '0, dinR = '0;
  logic         dinL_valid = 1'b0, dinR_valid = 1'b0;
  logic         dinL_ready, dinR_ready;
  logic [W-1:0] dout;
  logic         dout_valid, dout_last, dup;
  logic         dout_ready = 1'b1;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         dup;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] l_arr[RL];
  logic [W-1:0] r_arr[RL];
  int           li, ri;
  int           errors = 0;
  int           checks = 0;

  merge_unit #(.WIDTH(W), .RUN_LEN(RL)) dut (
    .clk        (clk),
    .rst        (rst),
    .dinL       (dinL),
    .dinL_valid (dinL_valid),
    .dinL_ready (dinL_ready),
    .dinR       (dinR),
    .dinR_valid (dinR_valid),
    .dinR_ready (dinR_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .dup        (dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stable two-way merge of l_arr/r_arr; dup marks a head-to-head tie anywhere in the run.
  task automatic push_expected();
    int   i = 0;
    int   j = 0;
    logic d = 1'b0;
    exp_t e;
    for (int k = 0; k < 2 * RL; k++) begin
      if (j >= RL || (i < RL && l_arr[i] <= r_arr[j])) begin
        if (i < RL && j < RL && l_arr[i] == r_arr[j]) d = 1'b1;
        e.data = l_arr[i];
        i++;
      end else begin
        e.data = r_arr[j];
        j++;
      end
      e.last = (k == 2 * RL - 1);
      e.dup  = e.last ? d : 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_case(input bit bp, input int stop_after, input bit drain_chk);
    int cyc = 0;
    int popped = 0;
    int acc = 0;
    bit prev_acc = 1'b0;
    li = 0;
    ri = 0;
    while (exp_q.size() > 0 && cyc < 300 && !(stop_after > 0 && popped >= stop_after)) begin
      @(negedge clk);
      dout_ready = bp ? (cyc % 3 == 0) : 1'b1;
      dinL_valid = (li < RL);
      dinR_valid = (ri < RL);
      dinL       = (li < RL) ? l_arr[li] : '0;
      dinR       = (ri < RL) ? r_arr[ri] : '0;
      #1;
      if (prev_acc) check("latency", 64'(dout_valid), 64'd1);
      if (dout_valid && exp_q.size() > 0) begin
        check("dout", 64'(dout), 64'(exp_q[0].data));
        check("dout_last", 64'(dout_last), 64'(exp_q[0].last));
        check("dup", 64'(dup), 64'(exp_q[0].dup));
        if (dout_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
      if (dout_valid && !dout_ready)
        check("stall_no_accept", 64'({dinL_ready, dinR_ready}), 64'd0);
      if (drain_chk && acc < RL && (dinL_ready || dinR_ready))
        check("drain_l_only", 64'({dinL_ready, dinR_ready}), 64'b10);
      prev_acc = dinL_ready || dinR_ready;
      if (dinL_ready) li++;
      if (dinR_ready) ri++;
      if (prev_acc) acc++;
      cyc++;
    end
    if (cyc >= 300) check("timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, 64'(dout), 64'd0);
    check({tag, "_flags"}, 64'({dout_valid, dout_last, dup}), 64'd0);
    check({tag, "_ready"}, 64'({dinL_ready, dinR_ready}), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    l_arr = '{32'd1, 32'd3, 32'd5, 32'd7};
    r_arr = '{32'd2, 32'd4, 32'd6, 32'd8};
    push_expected();
    run_case(1'b0, 0, 1'b0);

    l_arr = '{32'd1, 32'd2, 32'd3, 32'd4};
    r_arr = '{32'd5, 32'd6, 32'd7, 32'd8};
    push_expected();
    run_case(1'b0, 0, 1'b1);

    l_arr = '{32'd2, 32'd4, 32'd9, 32'd9};
    r_arr = '{32'd2, 32'd5, 32'd6, 32'd10};
    push_expected();
    run_case(1'b0, 0, 1'b0);

    l_arr = '{32'd1, 32'd3, 32'd5, 32'd7};
    r_arr = '{32'd2, 32'd4, 32'd6, 32'd8};
    push_expected();
    run_case(1'b1, 0, 1'b0);

    l_arr = '{32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF};
    r_arr = '{32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    push_expected();
    run_case(1'b0, 0, 1'b0);

    push_expected();
    run_case(1'b0, 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    dinL_valid = 1'b0;
    dinR_valid = 1'b0;

    l_arr = '{32'd1, 32'd3, 32'd5, 32'd7};
    r_arr = '{32'd2, 32'd4, 32'd6, 32'd8};
    push_expected();
    run_case(1'b0, 0, 1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/merge_unit.md
MERGE_UNIT -- requirements
Module: merge_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: key width in bits, unsigned.
REQ-002 SHALL have parameter RUN_LEN, default 16: words per input run, power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port dinL, input, WIDTH: current head word of the sorted left run.
REQ-006 SHALL have port dinL_valid, input, 1: dinL holds a valid word.
REQ-007 SHALL have port dinL_ready, output, 1: dinL is consumed this cycle.
REQ-008 SHALL have ports dinR / dinR_valid / dinR_ready, matching REQ-005..007 for the right run.
REQ-009 SHALL have port dout, output, WIDTH: merged word, registered.
REQ-010 SHALL have port dout_valid, output, 1: dout holds a valid word.
REQ-011 SHALL have port dout_ready, input, 1: downstream consumes dout this cycle.
REQ-012 SHALL have port dout_last, output, 1: dout is word 2*RUN_LEN of the merged run.
REQ-013 SHALL have port dup, output, 1: qualified by dout_last; the run contained at least one head-to-head equal key.

Function
REQ-014 SHALL merge one sorted left run and one sorted right run, each RUN_LEN words in ascending unsigned order, into one ascending run of 2*RUN_LEN words; runs repeat back-to-back.
REQ-015 SHALL compare dinL and dinR combinationally as unsigned WIDTH-bit values, producing L_smaller and equal with no sign or overflow effects, using the team's half-split compare block.
REQ-016 SHALL have FSM states IDLE, MERGE, DRAIN_L and DRAIN_R; IDLE is entered only on reset and always moves to MERGE on the next cycle.
REQ-017 SHALL define load_ok = !dout_valid || dout_ready; no input word is accepted unless load_ok is high.
REQ-018 In MERGE, SHALL consume from L (dinL_ready=1) when load_ok && dinL_valid && dinR_valid && (L_smaller || equal); otherwise, if load_ok and both valid, SHALL consume from R; if either valid is low, SHALL consume from neither.
REQ-019 On ties, SHALL take L first, which makes the merge stable.
REQ-020 SHALL keep counters cntL and cntR, each $clog2(RUN_LEN)+1 bits, incremented on each L or R handshake respectively.
REQ-021 When cntL reaches RUN_LEN in MERGE, SHALL move to DRAIN_R; when cntR reaches RUN_LEN, SHALL move to DRAIN_L; both counts cannot reach RUN_LEN in the same cycle.
REQ-022 In DRAIN_L, dinL_ready = load_ok && dinL_valid; dinR_ready = 0. DRAIN_R is symmetric. No comparison applies in either state.
REQ-023 SHALL register the accepted word into dout, with dout_valid=1 on the next cycle: latency is exactly one cycle.
REQ-024 SHALL hold dout, dout_last and dup stable while dout_valid && !dout_ready.
REQ-025 SHALL assert dout_last with the word for which cntL+cntR reaches 2*RUN_LEN; on that same edge SHALL clear both counters and return to MERGE.
REQ-026 SHALL set an internal sticky flag when equal=1 on an accepted MERGE handshake; dup SHALL equal (flag OR this cycle's equal) on the dout_last word; the flag SHALL clear when that last word is loaded.
REQ-027 SHALL keep dup=0 whenever dout_last=0.
REQ-028 SHALL allow a simultaneous output consume and input load in one cycle, sustaining one word per cycle.

Reset
REQ-029 On rst=1, SHALL immediately force state=IDLE, cntL=cntR=0, dup flag=0, dout=0, dout_valid=0, dout_last=0, dup=0, dinL_ready=0 and dinR_ready=0.
REQ-030 SHALL discard a partially merged run on reset mid-operation; after reset, the next input words are the start of a new run.

Verification (RUN_LEN=4, WIDTH=32)
REQ-031 Interleave case: L={1,3,5,7}, R={2,4,6,8}, all valid, dout_ready=1 -> dout is 1..8 on consecutive cycles, dout_last only with 8, dup=0.
REQ-032 Drain case: L={1,2,3,4}, R={5,6,7,8} -> state DRAIN_R after the 4th L word; output 1..8; dinR_ready=0 for the first 4 accepts.
REQ-033 Tie case: L={2,4,9,9}, R={2,5,6,10} -> L's 2 precedes R's 2; output 2,2,4,5,6,9,9,10; dup=1 with last.
REQ-034 Backpressure: same stimulus as REQ-031 with dout_ready toggling 1,0,0,1,... -> dout is stable while stalled; no input accepted while load_ok=0; sequence unchanged.
REQ-035 Extremes: L={0,0,1,0xFFFFFFFF}, R={0x80000000,...} -> unsigned order kept (0x80000000 after 1, before 0xFFFFFFFF).
REQ-036 Reset after 3 output words -> all outputs 0 the same cycle; a fresh REQ-031 run afterwards yields 1..8 correctly.
